// File: rtl/router_out_arbiter.sv
// router_out_arbiter: packet-level round-robin arbiter with XY route check for one router output port
`ifndef ROUTER_BUS_W
`define ROUTER_BUS_W 32
`endif
module router_out_arbiter #(
    parameter int         BUS_W   = `ROUTER_BUS_W,
    parameter int         N_IN    = 5,
    parameter logic [3:0] LOCAL_X = 4'd0,
    parameter logic [3:0] LOCAL_Y = 4'd0,
    parameter logic [2:0] OUT_DIR = 3'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN-1:0]       s_tvalid,
    output logic [N_IN-1:0]       s_tready,
    input  logic [N_IN*BUS_W-1:0] s_tdata,
    input  logic [N_IN-1:0]       s_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [BUS_W-1:0]      m_tdata,
    output logic                  m_tlast,
    output logic [2:0]            grant,
    output logic                  busy,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           drop_cnt
);
    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
    state_t      state_q;
    logic [2:0]  ptr_q, grant_q, ptr_d, sel;
    logic [15:0] pkt_cnt_q, drop_cnt_q;
    logic [3:0]  idx, dst_x, dst_y;
    logic [2:0]  dir;
    logic        found, g_valid, g_last, pass_done, drop_done;
    // Rotating first-set search starting at ptr_q
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        idx   = 4'd0;
        for (int k = 0; k < N_IN; k++) begin
            idx = {1'b0, ptr_q} + 4'(k);
            idx = idx >= 4'(N_IN) ? idx - 4'(N_IN) : idx;
            if (!found && s_tvalid[idx[2:0]]) begin
                found = 1'b1;
                sel   = idx[2:0];
            end
        end
    end
    // Header layout is src_x, src_y, dst_x, dst_y, ... from the MSB down
    assign dst_x = s_tdata[int'(sel)*BUS_W + BUS_W-9 -: 4];
    assign dst_y = s_tdata[int'(sel)*BUS_W + BUS_W-13 -: 4];
    assign dir   = dst_x > LOCAL_X ? 3'd2 :
                   dst_x < LOCAL_X ? 3'd4 :
                   dst_y > LOCAL_Y ? 3'd1 :
                   dst_y < LOCAL_Y ? 3'd3 : 3'd0;
    assign g_valid   = s_tvalid[grant_q];
    assign g_last    = s_tlast[grant_q];
    assign m_tdata   = s_tdata[int'(grant_q)*BUS_W +: BUS_W];
    assign m_tlast   = g_last;
    assign m_tvalid  = state_q == PASS && g_valid;
    assign s_tready  = state_q == PASS ? {{(N_IN-1){1'b0}}, m_tready} << grant_q :
                       state_q == DROP ? {{(N_IN-1){1'b0}}, 1'b1} << grant_q : '0;
    assign pass_done = m_tvalid && m_tready && g_last;
    assign drop_done = state_q == DROP && g_valid && g_last;
    assign ptr_d     = grant_q == 3'(N_IN-1) ? 3'd0 : grant_q + 3'd1;
    assign grant     = grant_q;
    assign busy      = state_q != IDLE;
    assign pkt_cnt   = pkt_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 3'd0;
            grant_q    <= 3'd0;
            pkt_cnt_q  <= 16'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    grant_q <= sel;
                    state_q <= dir == OUT_DIR ? PASS : DROP;
                end
                PASS: if (pass_done) begin
                    state_q   <= IDLE;
                    ptr_q     <= ptr_d;
                    pkt_cnt_q <= pkt_cnt_q + 16'(pkt_cnt_q != 16'hFFFF);
                end
                DROP: if (drop_done) begin
                    state_q    <= IDLE;
                    ptr_q      <= ptr_d;
                    drop_cnt_q <= drop_cnt_q + 16'(drop_cnt_q != 16'hFFFF);
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Packet-level round-robin arbiter for one router output port. It accepts up to N_IN AXI-stream input streams (virtual output queues from the router input stages) that carry rout_msg_t beats. It grants one input at a time and holds the grant until the packet's tlast, so packets are never interleaved. The header beat is checked against XY routing for this port; misrouted packets are consumed and dropped instead of forwarded.

## Interface
Parameters:
- BUS_W, `ROUTER_BUS_W: beat width; layout is rout_msg_t (src_x, src_y, dst_x, dst_y, mtype, data, MSB first).
- N_IN, 5: number of input streams, 2..8.
- LOCAL_X, 0: this router's X coordinate, 4-bit.
- LOCAL_Y, 0: this router's Y coordinate, 4-bit.
- OUT_DIR, 0: direction this port serves. 0 Local, 1 North, 2 East, 3 South, 4 West.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_tvalid  in  N_IN  per-input valid.
- s_tready  out  N_IN  per-input ready.
- s_tdata  in  N_IN*BUS_W  per-input beat; input i occupies bits [i*BUS_W +: BUS_W].
- s_tlast  in  N_IN  per-input end of packet.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tdata  out  BUS_W  output beat.
- m_tlast  out  1  output end of packet.
- grant  out  3  index of the input currently or last granted.
- busy  out  1  high when state is not IDLE.
- pkt_cnt  out  16  count of forwarded packets; saturates at 0xFFFF.
- drop_cnt  out  16  count of dropped packets; saturates at 0xFFFF.

## Operation
- Route function, applied to the header beat, X dimension first (dst fields are unsigned 4-bit):
  - dst_x > LOCAL_X gives East.
  - dst_x < LOCAL_X gives West.
  - Otherwise, dst_y > LOCAL_Y gives North and dst_y < LOCAL_Y gives South.
  - Otherwise, Local.
- The first beat after reset, and the first beat after any accepted tlast, is the header for that input.
- State machine:
  - IDLE:
    - s_tready = 0, m_tvalid = 0.
    - If any s_tvalid is high, select the first asserted index searching ptr, ptr+1, … modulo N_IN.
    - Register the selection into grant.
    - Go to PASS if route(header) == OUT_DIR, else go to DROP.
  - PASS:
    - m_tvalid = s_tvalid[grant], m_tdata = s_tdata[grant], m_tlast = s_tlast[grant], s_tready[grant] = m_tready.
    - All other s_tready are 0.
    - On a handshake with tlast: go to IDLE, set ptr = (grant+1) mod N_IN, increment pkt_cnt.
  - DROP:
    - s_tready[grant] = 1, m_tvalid = 0.
    - On s_tvalid[grant] && s_tlast[grant]: go to IDLE, set ptr = (grant+1) mod N_IN, increment drop_cnt.
- m_tdata and m_tlast are combinational muxes of the granted input. Their value is don't-care while m_tvalid = 0.
- A single-beat packet (header carries tlast) is legal in both PASS and DROP.
- Requests that arrive while the block is not in IDLE wait; there is no preemption.

## Timing
- Reset values: state IDLE, ptr 0, grant 0, pkt_cnt 0, drop_cnt 0, busy 0, m_tvalid 0, s_tready all 0.
- Arbitration latency is 1 cycle. If s_tvalid rises in cycle T during IDLE, the header is presented on m_* in cycle T+1.
- Data path latency is 0 cycles (combinational) while in PASS.
- Between packets there is exactly 1 IDLE cycle. Peak throughput for L-beat packets is L/(L+1).
- m_* follow the granted input combinationally, so upstream AXI stability rules carry through unchanged while m_tready = 0.
- Simultaneous requests are resolved by ptr; an input that was just served has lowest priority next.
- ptr wraps from N_IN-1 to 0.
- Counters saturate and never wrap.
- rst asserted mid-packet aborts the packet with no tlast emitted on m_*. Upstream is responsible for flushing.
- grant values ≥ N_IN never occur.

## Test plan
All scenarios use LOCAL_X=2, LOCAL_Y=2, OUT_DIR=2 (East), N_IN=5.
- Single packet: input 0, 3 beats, header dst=(5,1), m_tready=1 → header appears on m_* in the cycle after s_tvalid rises; 3 beats forwarded, tlast on beat 3; pkt_cnt=1; busy falls after tlast.
- Fairness: all 5 inputs continuously valid with 2-beat packets, dst_x=7 → grant sequence 0,1,2,3,4,0,1; packets never interleave; pkt_cnt=7 after 7 packets.
- Misroute: input 1, 4 beats, header dst=(2,5) (North) → s_tready[1]=1 for all 4 beats; m_tvalid stays 0; drop_cnt=1; pkt_cnt unchanged.
- Backpressure: input 3, 5-beat packet, m_tready pattern 1,0,0,1,0,1,1,1 → exactly 5 handshakes, m_tdata stable while stalled, s_tready[3] tracks m_tready.
- Single-beat back-to-back: inputs 2 and 4, each a header with tlast, dst_x=3 → outputs at cycles T+1 and T+3 with grant 2 then 4; pkt_cnt=2.
- Reset mid-packet: rst during beat 2 of a 4-beat packet on input 0 → next cycle m_tvalid=0, busy=0, counters 0; a fresh packet on input 0 then forwards normally.
